// File: rtl/piano_pkg.sv
// Shared types and helpers for the keyboard/song play controller.
// Holds the FSM state encoding and the song-index one-hot helper.
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        HOLD,
        SONG
    } state_t;

    localparam int NOTE_REST      = 0;
    localparam int STOP_CODE_DFLT = 99;
    localparam int MAX_SONGS      = 32;

    function automatic logic [MAX_SONGS-1:0] onehot_from_idx(
        input int unsigned idx
    );
        logic [MAX_SONGS-1:0] oh;
        oh = '0;
        if (idx != 0 && idx <= MAX_SONGS)
            oh = MAX_SONGS'(1) << (idx - 1);
        return oh;
    endfunction

endpackage

// File: rtl/play_controller_if.sv
// Key/song inputs and buzzer/sequencer outputs of the play controller.
// The master side drives inputs, the slave side is the controller.
interface play_controller_if #(
    parameter int NOTE_W    = 8,
    parameter int NUM_SONGS = 4,
    parameter int IDX_W     = $clog2(NUM_SONGS + 1)
);

    logic [NOTE_W-1:0]           iPs2_Data;
    logic [NUM_SONGS*NOTE_W-1:0] iSong_Data;
    logic [NUM_SONGS-1:0]        iSongSelect;
    logic [NUM_SONGS-1:0]        iSongEnd;
    logic [NOTE_W-1:0]           oFreq_Data;
    logic                        oCountEnable;
    logic [IDX_W-1:0]            oSongIdx;
    logic [NUM_SONGS-1:0]        oSongSelectSeq;
    logic                        oSongStart;

    modport master (
        output iPs2_Data, iSong_Data, iSongSelect, iSongEnd,
        input  oFreq_Data, oCountEnable, oSongIdx,
        input  oSongSelectSeq, oSongStart
    );

    modport slave (
        input  iPs2_Data, iSong_Data, iSongSelect, iSongEnd,
        output oFreq_Data, oCountEnable, oSongIdx,
        output oSongSelectSeq, oSongStart
    );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector; history resets to all-ones so a level
// already high when reset releases is not seen as a press.
module edge_detect #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prev <= '1;
        else
            prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/play_controller.sv
// Arbitrates live PS/2 key notes against built-in songs and drives
// the buzzer note code, counter enable and song sequencer controls.
module play_controller
    import piano_pkg::*;
#(
    parameter int NOTE_W      = 8,
    parameter int NUM_SONGS   = 4,
    parameter int IDX_W       = $clog2(NUM_SONGS + 1),
    parameter int HOLD_CYCLES = 0,
    parameter int STOP_CODE   = STOP_CODE_DFLT
) (
    input  logic              iClk,
    input  logic              iReset_n,
    play_controller_if.slave  bus
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NOTE_W-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NOTE_W-1:0]     freq_q, freq_d;
    logic                  en_q, en_d;
    logic [NUM_SONGS-1:0]  seq_q, seq_d;
    logic                  start_q, start_d;

    logic [NUM_SONGS-1:0]  rise;
    logic [IDX_W-1:0]      sel;
    logic                  end_hit;
    logic                  key_ok;
    logic [NOTE_W-1:0]     slice;
    logic [MAX_SONGS-1:0]  oh;

    edge_detect #(.W(NUM_SONGS)) u_btn (
        .clk   (iClk),
        .rst_n (iReset_n),
        .level (bus.iSongSelect),
        .rise  (rise)
    );

    assign key_ok = (bus.iPs2_Data != '0) &&
                    (bus.iPs2_Data != NOTE_W'(STOP_CODE));

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            freq_q  <= '0;
            en_q    <= 1'b0;
            seq_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            freq_q  <= freq_d;
            en_q    <= en_d;
            seq_q   <= seq_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        start_d = 1'b0;
        sel     = '0;
        end_hit = 1'b0;

        // Scan high to low so the lowest pressed button wins.
        for (int k = NUM_SONGS - 1; k >= 0; k--) begin
            if (rise[k])
                sel = IDX_W'(k + 1);
        end
        for (int k = 0; k < NUM_SONGS; k++) begin
            if (idx_q == IDX_W'(k + 1) && bus.iSongEnd[k])
                end_hit = 1'b1;
        end

        if (rise != '0) begin
            if (state_q == SONG && sel == idx_q) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                state_d = SONG;
                idx_d   = sel;
                start_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (key_ok) begin
                        state_d = KEY;
                        hold_d  = bus.iPs2_Data;
                    end
                end
                KEY: begin
                    if (key_ok) begin
                        hold_d = bus.iPs2_Data;
                    end else if (HOLD_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (key_ok) begin
                        state_d = KEY;
                        hold_d  = bus.iPs2_Data;
                    end else if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SONG: begin
                    if (end_hit) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        slice  = '0;
        freq_d = NOTE_W'(NOTE_REST);
        en_d   = 1'b0;
        oh     = onehot_from_idx(int'(idx_d));
        seq_d  = '0;

        for (int k = 0; k < NUM_SONGS; k++) begin
            if (idx_d == IDX_W'(k + 1))
                slice = bus.iSong_Data[k*NOTE_W +: NOTE_W];
        end

        unique case (state_d)
            IDLE: begin
                freq_d = NOTE_W'(NOTE_REST);
            end
            KEY: begin
                freq_d = bus.iPs2_Data;
                en_d   = 1'b1;
            end
            HOLD: begin
                freq_d = hold_d;
                en_d   = 1'b1;
            end
            SONG: begin
                freq_d = slice;
                en_d   = 1'b1;
                seq_d  = oh[NUM_SONGS-1:0];
            end
            default: freq_d = NOTE_W'(NOTE_REST);
        endcase
    end

    assign bus.oFreq_Data     = freq_q;
    assign bus.oCountEnable   = en_q;
    assign bus.oSongIdx       = idx_q;
    assign bus.oSongSelectSeq = seq_q;
    assign bus.oSongStart     = start_q;

endmodule

// File: tb/tb_play_controller.sv
// Bench for play_controller: two instances (3-cycle sustain and none)
// driven in lockstep and compared to a behavioural model every cycle.
module tb_play_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ps2 = '0;
    logic [31:0] song_data = '0;
    logic [3:0]  sel = '0;
    logic [3:0]  send = '0;

    int errs = 0;
    int checks = 0;

    play_controller_if #(.NOTE_W(8), .NUM_SONGS(4)) if3 ();
    play_controller_if #(.NOTE_W(8), .NUM_SONGS(4)) if0 ();

    assign if3.iPs2_Data   = ps2;
    assign if3.iSong_Data  = song_data;
    assign if3.iSongSelect = sel;
    assign if3.iSongEnd    = send;
    assign if0.iPs2_Data   = ps2;
    assign if0.iSong_Data  = song_data;
    assign if0.iSongSelect = sel;
    assign if0.iSongEnd    = send;

    play_controller #(.HOLD_CYCLES(3)) d3 (
        .iClk(clk), .iReset_n(rst_n), .bus(if3)
    );
    play_controller #(.HOLD_CYCLES(0)) d0 (
        .iClk(clk), .iReset_n(rst_n), .bus(if0)
    );

    always #5 clk = ~clk;

    // Model: d=0 is the 3-cycle sustain instance, d=1 has none.
    logic [3:0] m_prev;
    int m_song[2];
    bit m_key[2];
    int m_left[2];
    int m_hnote[2];
    bit m_start[2];

    task automatic chk(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = 4'hF;
        for (int d = 0; d < 2; d++) begin
            m_song[d]  = 0;
            m_key[d]   = 0;
            m_left[d]  = 0;
            m_hnote[d] = 0;
            m_start[d] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] rise;
        int j;
        int hc;
        bit valid;
        rise = sel & ~m_prev;
        m_prev = sel;
        j = -1;
        for (int k = 3; k >= 0; k--)
            if (rise[k]) j = k;
        valid = (ps2 != 0) && (ps2 != 99);
        for (int d = 0; d < 2; d++) begin
            hc = (d == 0) ? 3 : 0;
            m_start[d] = 0;
            if (j >= 0) begin
                if (m_song[d] == j + 1) begin
                    m_song[d] = 0;
                end else begin
                    m_song[d] = j + 1;
                    m_start[d] = 1;
                end
                m_key[d] = 0;
                m_left[d] = 0;
            end else if (m_song[d] != 0) begin
                if (send[m_song[d]-1]) m_song[d] = 0;
            end else if (valid) begin
                m_key[d] = 1;
                m_hnote[d] = int'(ps2);
                m_left[d] = 0;
            end else if (m_key[d]) begin
                m_key[d] = 0;
                m_left[d] = hc;
            end else if (m_left[d] > 0) begin
                m_left[d]--;
            end
        end
    endtask

    function automatic int exp_freq(int d);
        if (m_song[d] != 0)
            return int'((song_data >> ((m_song[d] - 1) * 8)) & 32'hFF);
        if (m_key[d] || m_left[d] > 0)
            return m_hnote[d];
        return 0;
    endfunction

    function automatic int exp_en(int d);
        return (m_song[d] != 0 || m_key[d] || m_left[d] > 0) ? 1 : 0;
    endfunction

    function automatic int exp_seq(int d);
        return (m_song[d] != 0) ? (1 << (m_song[d] - 1)) : 0;
    endfunction

    task automatic check_all();
        chk("h3_freq",  int'(if3.oFreq_Data),     exp_freq(0));
        chk("h3_en",    int'(if3.oCountEnable),   exp_en(0));
        chk("h3_idx",   int'(if3.oSongIdx),       m_song[0]);
        chk("h3_seq",   int'(if3.oSongSelectSeq), exp_seq(0));
        chk("h3_start", int'(if3.oSongStart),     int'(m_start[0]));
        chk("h0_freq",  int'(if0.oFreq_Data),     exp_freq(1));
        chk("h0_en",    int'(if0.oCountEnable),   exp_en(1));
        chk("h0_idx",   int'(if0.oSongIdx),       m_song[1]);
        chk("h0_seq",   int'(if0.oSongSelectSeq), exp_seq(1));
        chk("h0_start", int'(if0.oSongStart),     int'(m_start[1]));
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            check_all();
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_freq", int'(if3.oFreq_Data), 0);
        chk("rst_en", int'(if3.oCountEnable), 0);
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        sel = 4'b0001;
        #12;
        check_all();
        step(2);
        rst_n = 1'b1;
        step(4);
        sel = 4'b0000; step(2);
        sel = 4'b0001; step(1);
        chk("btn_restart", int'(if3.oSongStart), 1);
        sel = 4'b0000; step(1);
        sel = 4'b0001; step(1);
        sel = 4'b0000; step(1);

        ps2 = 8'h1C; step(5);
        ps2 = 8'd99; step(1);
        chk("hold_first", int'(if3.oFreq_Data), 8'h1C);
        chk("nohold_drop", int'(if0.oCountEnable), 0);
        step(2);
        chk("hold_last", int'(if3.oCountEnable), 1);
        step(1);
        chk("hold_end", int'(if3.oCountEnable), 0);
        ps2 = 8'h00; step(2);

        song_data = 32'h0000_2500;
        sel = 4'b0010; step(1);
        chk("s2_idx", int'(if3.oSongIdx), 2);
        chk("s2_seq", int'(if3.oSongSelectSeq), 2);
        chk("s2_freq", int'(if3.oFreq_Data), 8'h25);
        sel = 4'b0000;
        ps2 = 8'h1C; step(3);
        chk("s2_keyignored", int'(if3.oFreq_Data), 8'h25);
        ps2 = 8'h00;
        sel = 4'b0100; step(1);
        sel = 4'b0000; step(1);
        sel = 4'b0100; step(1);
        chk("s3_stop", int'(if3.oCountEnable), 0);
        sel = 4'b0000; step(1);

        song_data = 32'h4433_2211;
        sel = 4'b0001; step(1);
        sel = 4'b0000; step(2);
        send = 4'b0010; step(1);
        send = 4'b0000; step(2);
        send = 4'b0001; step(1);
        send = 4'b0000; step(1);
        sel = 4'b0001; step(1);
        sel = 4'b0000; step(1);
        send = 4'b0001; sel = 4'b0010; step(1);
        chk("end_vs_rise", int'(if3.oSongIdx), 2);
        send = 4'b0000; sel = 4'b0000; step(1);
        sel = 4'b0010; step(1);
        sel = 4'b0000; step(1);

        sel = 4'b1010; step(1);
        chk("multi_rise", int'(if3.oSongIdx), 2);
        sel = 4'b0000; step(2);
        async_reset();
        step(3);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15) ps2 = 8'h00;
            else if (r < 35) ps2 = 8'd99;
            else if (r < 45) ps2 = 8'h1C;
            else if (r < 55) ps2 = 8'($urandom);
            song_data = $urandom;
            if ($urandom_range(0, 9) == 0)
                sel = sel ^ (4'b0001 << $urandom_range(0, 3));
            send = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 299) == 0) async_reset();
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
